// File: rtl/retire_stage.sv
// In-order commit stage: retires the longest completed prefix of the ROB head,
// frees old tags, updates the architectural map, and sequences flush/halt.
module retire_stage #(
   parameter int N                = 3,
   parameter int PHYS_REG_ID_BITS = 6,
   parameter int ARCH_REG_ID_BITS = 5,
   parameter int XLEN             = 32,
   parameter int RECOVERY_CYCLES  = 2
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [$clog2(N+1)-1:0]        outputs_valid,
   input  logic [N-1:0]                  rob_complete,
   input  logic [N-1:0]                  rob_mispredict,
   input  logic [N-1:0]                  rob_halt,
   input  logic [N*PHYS_REG_ID_BITS-1:0] rob_t_new,
   input  logic [N*PHYS_REG_ID_BITS-1:0] rob_t_old,
   input  logic [N*ARCH_REG_ID_BITS-1:0] rob_arch_reg,
   input  logic [N*XLEN-1:0]             rob_target_pc,
   output logic [$clog2(N+1)-1:0]        num_retiring,
   output logic [N-1:0]                  free_valid,
   output logic [N*PHYS_REG_ID_BITS-1:0] free_reg,
   output logic [N-1:0]                  map_we,
   output logic [N*ARCH_REG_ID_BITS-1:0] map_reg,
   output logic [N*PHYS_REG_ID_BITS-1:0] map_tag,
   output logic                          flush,
   output logic [XLEN-1:0]               redirect_pc,
   output logic                          halted,
   output logic [63:0]                   retired_count
);

   localparam int CNT_W = $clog2(N+1);
   localparam int REC_W = $clog2(RECOVERY_CYCLES+1);

   typedef enum logic [1:0] {S_RUN, S_RECOVER, S_HALTED} state_t;

   state_t             state_q, state_d;
   logic [REC_W-1:0]   rec_q, rec_d;
   logic               flush_q, flush_d;
   logic [XLEN-1:0]    redirect_q, redirect_d;
   logic               halted_q, halted_d;
   logic [63:0]        count_q, count_d;

   int                 valid_n;
   int                 k_n;
   logic               stop;
   logic               ev_halt;
   logic               ev_mis;
   logic [XLEN-1:0]    ev_pc;

   // Scan the head: retire completed entries in order, ending just after the
   // first halt or mispredict so nothing younger than it commits.
   always_comb begin
      valid_n = int'(outputs_valid);
      if (valid_n > N) valid_n = N;
      k_n     = 0;
      stop    = 1'b0;
      ev_halt = 1'b0;
      ev_mis  = 1'b0;
      ev_pc   = '0;
      if (reset && state_q == S_RUN) begin
         for (int i = 0; i < N; i++) begin
            if (!stop) begin
               if (i < valid_n && rob_complete[i]) begin
                  k_n = i + 1;
                  if (rob_halt[i]) begin
                     ev_halt = 1'b1;
                     stop    = 1'b1;
                  end else if (rob_mispredict[i]) begin
                     ev_mis  = 1'b1;
                     ev_pc   = rob_target_pc[i*XLEN +: XLEN];
                     stop    = 1'b1;
                  end
               end else begin
                  stop = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      free_valid = '0;
      free_reg   = '0;
      map_we     = '0;
      map_reg    = '0;
      map_tag    = '0;
      for (int i = 0; i < N; i++) begin
         if (i < k_n) begin
            free_valid[i] = |rob_arch_reg[i*ARCH_REG_ID_BITS +: ARCH_REG_ID_BITS];
            map_we[i]     = |rob_arch_reg[i*ARCH_REG_ID_BITS +: ARCH_REG_ID_BITS];
            free_reg[i*PHYS_REG_ID_BITS +: PHYS_REG_ID_BITS] =
               rob_t_old[i*PHYS_REG_ID_BITS +: PHYS_REG_ID_BITS];
            map_tag[i*PHYS_REG_ID_BITS +: PHYS_REG_ID_BITS] =
               rob_t_new[i*PHYS_REG_ID_BITS +: PHYS_REG_ID_BITS];
            map_reg[i*ARCH_REG_ID_BITS +: ARCH_REG_ID_BITS] =
               rob_arch_reg[i*ARCH_REG_ID_BITS +: ARCH_REG_ID_BITS];
         end
      end
   end

   assign num_retiring = CNT_W'(k_n);

   always_comb begin
      state_d    = state_q;
      rec_d      = rec_q;
      flush_d    = 1'b0;
      redirect_d = redirect_q;
      halted_d   = halted_q;
      count_d    = count_q + 64'(k_n);
      unique case (state_q)
         S_RUN: begin
            if (ev_halt) begin
               state_d  = S_HALTED;
               halted_d = 1'b1;
            end else if (ev_mis) begin
               state_d    = S_RECOVER;
               flush_d    = 1'b1;
               redirect_d = ev_pc;
               rec_d      = REC_W'(RECOVERY_CYCLES);
            end
         end
         S_RECOVER: begin
            if (rec_q <= REC_W'(1)) begin
               state_d = S_RUN;
               rec_d   = '0;
            end else begin
               rec_d = rec_q - REC_W'(1);
            end
         end
         S_HALTED: ;
         default: state_d = S_RUN;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= S_RUN;
         rec_q      <= '0;
         flush_q    <= 1'b0;
         redirect_q <= '0;
         halted_q   <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         rec_q      <= rec_d;
         flush_q    <= flush_d;
         redirect_q <= redirect_d;
         halted_q   <= halted_d;
         count_q    <= count_d;
      end
   end

   assign flush         = flush_q;
   assign redirect_pc   = redirect_q;
   assign halted        = halted_q;
   assign retired_count = count_q;

endmodule

// File: tb/tb_retire_stage.sv
// Scoreboard bench for retire_stage: a stimulus process pushes expected
// responses from a prefix-scan reference model; a negedge monitor checks them.
`timescale 1ns/1ps
module tb_retire_stage;

   localparam int N  = 3;
   localparam int P  = 6;
   localparam int A  = 5;
   localparam int X  = 32;
   localparam int RC = 2;
   localparam int CW = $clog2(N+1);

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic [CW-1:0]   outputs_valid;
   logic [N-1:0]    rob_complete, rob_mispredict, rob_halt;
   logic [N*P-1:0]  rob_t_new, rob_t_old;
   logic [N*A-1:0]  rob_arch_reg;
   logic [N*X-1:0]  rob_target_pc;
   logic [CW-1:0]   num_retiring;
   logic [N-1:0]    free_valid, map_we;
   logic [N*P-1:0]  free_reg, map_tag;
   logic [N*A-1:0]  map_reg;
   logic            flush, halted;
   logic [X-1:0]    redirect_pc;
   logic [63:0]     retired_count;

   retire_stage #(.N(N), .PHYS_REG_ID_BITS(P), .ARCH_REG_ID_BITS(A),
                  .XLEN(X), .RECOVERY_CYCLES(RC)) dut (
      .clock(clock), .reset(reset), .outputs_valid(outputs_valid),
      .rob_complete(rob_complete), .rob_mispredict(rob_mispredict),
      .rob_halt(rob_halt), .rob_t_new(rob_t_new), .rob_t_old(rob_t_old),
      .rob_arch_reg(rob_arch_reg), .rob_target_pc(rob_target_pc),
      .num_retiring(num_retiring), .free_valid(free_valid), .free_reg(free_reg),
      .map_we(map_we), .map_reg(map_reg), .map_tag(map_tag), .flush(flush),
      .redirect_pc(redirect_pc), .halted(halted), .retired_count(retired_count)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [CW-1:0]  nr;
      logic [N-1:0]   fv;
      logic [N*P-1:0] fr;
      logic [N-1:0]   mwe;
      logic [N*A-1:0] mr;
      logic [N*P-1:0] mt;
      logic           fl;
      logic [X-1:0]   pc;
      logic           h;
      logic [63:0]    rc;
   } exp_t;

   exp_t        q[$];
   exp_t        mon_e;
   int          n_checks = 0;
   int          n_fail   = 0;

   bit          m_halted = 0;
   bit          m_flush  = 0;
   int          m_left   = 0;
   logic [X-1:0] m_pc    = '0;
   logic [63:0] m_count  = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (q.size() > 0) begin
         mon_e = q.pop_front();
         chk("num_retiring",  64'(num_retiring),  64'(mon_e.nr));
         chk("free_valid",    64'(free_valid),    64'(mon_e.fv));
         chk("free_reg",      64'(free_reg),      64'(mon_e.fr));
         chk("map_we",        64'(map_we),        64'(mon_e.mwe));
         chk("map_reg",       64'(map_reg),       64'(mon_e.mr));
         chk("map_tag",       64'(map_tag),       64'(mon_e.mt));
         chk("flush",         64'(flush),         64'(mon_e.fl));
         chk("redirect_pc",   64'(redirect_pc),   64'(mon_e.pc));
         chk("halted",        64'(halted),        64'(mon_e.h));
         chk("retired_count", retired_count,      mon_e.rc);
      end
   end

   // Reference model: retire count is the completed prefix, cut after the
   // first halt/mispredict inside it; control is tracked as plain flags.
   task automatic commit();
      exp_t e;
      int v, c, k;
      bit ev_h, ev_m;
      logic [X-1:0] tgt;
      e = '0; k = 0; ev_h = 0; ev_m = 0; tgt = '0;
      e.fl = m_flush; e.pc = m_pc; e.h = m_halted; e.rc = m_count;
      if (reset && !m_halted && m_left == 0) begin
         v = int'(outputs_valid);
         if (v > N) v = N;
         c = 0;
         while (c < v && rob_complete[c]) c++;
         k = c;
         for (int m = 0; m < c; m++) begin
            if (rob_mispredict[m] || rob_halt[m]) begin
               k    = m + 1;
               ev_h = rob_halt[m];
               ev_m = !rob_halt[m];
               tgt  = rob_target_pc[m*X +: X];
               break;
            end
         end
         e.nr = CW'(k);
         for (int i = 0; i < k; i++) begin
            e.fv[i]          = (rob_arch_reg[i*A +: A] != 0);
            e.mwe[i]         = e.fv[i];
            e.fr[i*P +: P]   = rob_t_old[i*P +: P];
            e.mt[i*P +: P]   = rob_t_new[i*P +: P];
            e.mr[i*A +: A]   = rob_arch_reg[i*A +: A];
         end
      end
      q.push_back(e);
      if (!reset) begin
         m_halted = 0; m_flush = 0; m_left = 0; m_pc = '0; m_count = '0;
      end else begin
         m_flush = 0;
         if (m_halted) begin
         end else if (m_left > 0) begin
            m_left--;
         end else begin
            m_count += 64'(k);
            if (ev_h) m_halted = 1;
            else if (ev_m) begin
               m_flush = 1; m_pc = tgt; m_left = RC;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_in();
      reset = 1'b1; outputs_valid = '0; rob_complete = '0; rob_mispredict = '0;
      rob_halt = '0; rob_t_new = '0; rob_t_old = '0; rob_arch_reg = '0; rob_target_pc = '0;
   endtask

   task automatic set_slot(input int i, input bit c, input bit mi, input bit h,
                           input int ar, input int to, input int tn, input logic [X-1:0] pc);
      rob_complete[i] = c; rob_mispredict[i] = mi; rob_halt[i] = h;
      rob_arch_reg[i*A +: A] = A'(ar);
      rob_t_old[i*P +: P] = P'(to);
      rob_t_new[i*P +: P] = P'(tn);
      rob_target_pc[i*X +: X] = pc;
   endtask

   task automatic full_head();
      clear_in();
      outputs_valid = CW'(3);
      set_slot(0, 1, 0, 0, 5, 10, 20, 32'h100);
      set_slot(1, 1, 0, 0, 6, 11, 21, 32'h104);
      set_slot(2, 1, 0, 0, 7, 12, 22, 32'h108);
   endtask

   task automatic rand_inputs();
      reset = ($urandom_range(0, 29) != 0);
      outputs_valid = CW'($urandom_range(0, 3));
      for (int i = 0; i < N; i++) begin
         rob_complete[i]   = ($urandom_range(0, 3) != 0);
         rob_mispredict[i] = ($urandom_range(0, 9) == 0);
         rob_halt[i]       = ($urandom_range(0, 39) == 0);
         rob_arch_reg[i*A +: A] = ($urandom_range(0, 7) == 0) ? A'(0) : A'($urandom_range(1, 31));
         rob_t_old[i*P +: P] = P'($urandom);
         rob_t_new[i*P +: P] = P'($urandom);
         rob_target_pc[i*X +: X] = $urandom;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      clear_in(); reset = 1'b0;
      tick(); clear_in(); reset = 1'b0; commit();
      tick(); full_head(); commit();
      tick(); full_head(); rob_complete = 3'b101; commit();
      tick(); full_head(); rob_complete = 3'b110; commit();
      tick(); full_head(); outputs_valid = CW'(2); commit();
      tick(); full_head(); set_slot(0, 1, 0, 0, 0, 13, 23, 32'h0); commit();
      tick(); full_head(); set_slot(1, 1, 1, 0, 6, 11, 21, 32'h40); commit();
      tick(); full_head(); commit();
      tick(); full_head(); commit();
      tick(); full_head(); commit();
      tick(); full_head(); set_slot(1, 1, 1, 1, 6, 11, 21, 32'h80); commit();
      tick(); clear_in(); reset = 1'b0; commit();
      tick(); full_head(); set_slot(0, 1, 0, 1, 5, 10, 20, 32'h0); commit();
      for (int i = 0; i < 10; i++) begin
         tick(); full_head(); commit();
      end
      tick(); full_head(); reset = 1'b0; commit();
      tick(); full_head(); commit();
      for (int i = 0; i < 2000; i++) begin
         tick(); rand_inputs(); commit();
      end
      tick(); clear_in();
      @(negedge clock);
      #1;
      chk("scoreboard_drain", 64'(q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
